// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg
//   Shared types for the picoMIPS program-counter sequencer.
//   op_t    : control opcode carried by the fetched instruction.
//   state_t : sequencer mode (running, waiting on go, halted).
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ALU  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BEQ  = 3'd2,
    OP_BNE  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_WAIT = 3'd6,
    OP_HALT = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if
//   Bundle between the program ROM/decoder, the sequencer and the pc block.
//   Inputs to the sequencer : PCin, op, target, zero, go
//   Outputs of the sequencer: PCincr, Branchaddr, stall, halted, stk_err
//   modport master : the fetch/decode side (drives instruction fields, sees decisions)
//   modport slave  : the sequencer itself
interface pc_ctrl_if import pc_ctrl_pkg::*; #(
  parameter int Psize = 6
);

  logic [Psize-1:0] PCin;
  op_t              op;
  logic [Psize-1:0] target;
  logic             zero;
  logic             go;
  logic             PCincr;
  logic [Psize-1:0] Branchaddr;
  logic             stall;
  logic             halted;
  logic             stk_err;

  modport master (
    output PCin, op, target, zero, go,
    input  PCincr, Branchaddr, stall, halted, stk_err
  );

  modport slave (
    input  PCin, op, target, zero, go,
    output PCincr, Branchaddr, stall, halted, stk_err
  );

endinterface

// File: rtl/pc_ctrl_ret_stack.sv
// ret_stack
//   LIFO of return addresses for CALL/RET.
//   clk, reset : clock, synchronous active-high reset (clears the entry count only)
//   push, din  : store din on top (ignored when full)
//   pop        : discard top entry (ignored when empty)
//   dout       : current top entry (meaningless when empty)
//   full/empty : count==STK_DEPTH / count==0
module ret_stack #(
  parameter int Psize     = 6,
  parameter int STK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Psize-1:0] din,
  output logic [Psize-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(STK_DEPTH);
  localparam logic [AW:0] DEPTH_C = STK_DEPTH[AW:0];

  logic [AW:0]      cnt_q;
  logic [Psize-1:0] mem [STK_DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  // With a power-of-2 depth the low count bits wrap to 0 when full, so
  // wr_idx-1 still names the top entry in that case.
  assign wr_idx = cnt_q[AW-1:0];
  assign rd_idx = wr_idx - 1'b1;
  assign full   = (cnt_q == DEPTH_C);
  assign empty  = (cnt_q == '0);
  assign dout   = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl
//   Program-counter sequencer for picoMIPS. Each cycle it looks at the current
//   PC and the control fields of the fetched instruction and tells the pc block
//   either to increment (PCincr=1) or to load Branchaddr (PCincr=0). Decisions
//   are combinational from state and inputs; the PC changes on the next edge.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pc_ctrl_if.slave (PCin, op, target, zero, go in;
//                PCincr, Branchaddr, stall, halted, stk_err out)
module pc_ctrl import pc_ctrl_pkg::*; #(
  parameter int Psize     = 6,
  parameter int STK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  pc_ctrl_if.slave    bus
);

  state_t                  state_q, state_d;
  logic                    go_meta_q, go_s_q;
  logic                    err_q;
  logic                    push, pop, err_set;
  logic                    full, empty;
  logic [Psize-1:0]        stk_top;
  logic signed [Psize-1:0] add_b;
  logic [Psize-1:0]        sum;
  logic                    incr, stall, halted;
  logic [Psize-1:0]        baddr;

  // Two's-complement add truncated to Psize bits: a sign-extended offset
  // and a plain unsigned add give the same wrapped result.
  function automatic logic [Psize-1:0] wrap_add(input logic [Psize-1:0] a,
                                                input logic signed [Psize-1:0] b);
    return a + $unsigned(b);
  endfunction

  // One shared adder: relative offset for conditional branches, +1 otherwise
  // (the +1 result is the CALL return address).
  assign add_b = (bus.op == OP_BEQ || bus.op == OP_BNE) ? $signed(bus.target)
                                                         : {{(Psize-1){1'b0}}, 1'b1};
  assign sum   = wrap_add(bus.PCin, add_b);

  ret_stack #(.Psize(Psize), .STK_DEPTH(STK_DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (sum),
    .dout  (stk_top),
    .full  (full),
    .empty (empty)
  );

  // go is asynchronous: two flops before any decision looks at it.
  always_ff @(posedge clk) begin
    if (reset) begin
      go_meta_q <= 1'b0;
      go_s_q    <= 1'b0;
    end else begin
      go_meta_q <= bus.go;
      go_s_q    <= go_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    incr    = 1'b1;
    baddr   = sum;
    stall   = 1'b0;
    halted  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (reset) begin
      incr    = 1'b0;
      baddr   = '0;
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          case (bus.op)
            OP_ALU: incr = 1'b1;
            OP_JMP: begin
              incr  = 1'b0;
              baddr = bus.target;
            end
            OP_BEQ: incr = !bus.zero;
            OP_BNE: incr = bus.zero;
            OP_CALL: begin
              // Overflow drops the return address but still takes the jump.
              incr    = 1'b0;
              baddr   = bus.target;
              push    = !full;
              err_set = full;
            end
            OP_RET: begin
              if (empty) begin
                incr    = 1'b1;
                err_set = 1'b1;
              end else begin
                incr  = 1'b0;
                baddr = stk_top;
                pop   = 1'b1;
              end
            end
            OP_WAIT: begin
              if (go_s_q != bus.target[0]) begin
                incr    = 1'b0;
                baddr   = bus.PCin;
                stall   = 1'b1;
                state_d = S_WAIT;
              end
            end
            OP_HALT: begin
              incr    = 1'b0;
              baddr   = bus.PCin;
              stall   = 1'b1;
              state_d = S_HALT;
            end
          endcase
        end
        S_WAIT: begin
          // PC is held, so op/target still describe the WAIT instruction.
          if (go_s_q == bus.target[0]) begin
            state_d = S_RUN;
          end else begin
            incr  = 1'b0;
            baddr = bus.PCin;
            stall = 1'b1;
          end
        end
        S_HALT: begin
          incr   = 1'b0;
          baddr  = bus.PCin;
          stall  = 1'b1;
          halted = 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  assign bus.PCincr     = incr;
  assign bus.Branchaddr = baddr;
  assign bus.stall      = stall;
  assign bus.halted     = halted;
  assign bus.stk_err    = err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl
//   Directed scenarios with literal expectations, then a random program run
//   from a ROM; a reference model (mode + return-address queue + go delay line)
//   is compared with the DUT on every negative clock edge.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  localparam int PS    = 6;
  localparam int DEPTH = 4;
  localparam int MR = 0, MW = 1, MH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_ctrl_if #(.Psize(PS)) bus ();
  pc_ctrl #(.Psize(PS), .STK_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode = MR;
  int stk[$];
  bit m_err = 1'b0;
  bit g1 = 1'b0, gs = 1'b0;
  int pc = 0;
  bit chk_en = 1'b0;

  op_t rom_op [64];
  int  rom_tgt[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // What the outputs must be this cycle, from the current model state and inputs.
  function automatic void model_eval(output bit incr, output int addr,
                                     output bit st, output bit hl);
    int pcin, tgt, off;
    bit hold;
    pcin = int'(bus.PCin);
    tgt  = int'(bus.target);
    off  = (tgt >= 32) ? tgt - 64 : tgt;
    incr = 1'b1; addr = 0; st = 1'b0; hl = 1'b0; hold = 1'b0;
    if (reset) begin
      incr = 1'b0;
      return;
    end
    if (m_mode == MH) begin
      hold = 1'b1; hl = 1'b1;
    end else if (m_mode == MW) begin
      hold = (int'(gs) != tgt % 2);
    end else begin
      case (bus.op)
        OP_ALU:  incr = 1'b1;
        OP_JMP:  begin incr = 1'b0; addr = tgt; end
        OP_BEQ:  if (bus.zero)  begin incr = 1'b0; addr = (pcin + off + 64) % 64; end
        OP_BNE:  if (!bus.zero) begin incr = 1'b0; addr = (pcin + off + 64) % 64; end
        OP_CALL: begin incr = 1'b0; addr = tgt; end
        OP_RET:  if (stk.size() > 0) begin incr = 1'b0; addr = stk[$]; end
        OP_WAIT: hold = (int'(gs) != tgt % 2);
        OP_HALT: hold = 1'b1;
        default: incr = 1'b1;
      endcase
    end
    if (hold) begin
      incr = 1'b0; addr = pcin; st = 1'b1;
    end
  endfunction

  // Compare process.
  always @(negedge clk) begin
    bit ei, es, eh;
    int ea;
    if (chk_en) begin
      model_eval(ei, ea, es, eh);
      check("PCincr", {31'b0, bus.PCincr}, {31'b0, ei});
      if (!ei) check("Branchaddr", {26'b0, bus.Branchaddr}, ea);
      check("stall", {31'b0, bus.stall}, {31'b0, es});
      check("halted", {31'b0, bus.halted}, {31'b0, eh});
      check("stk_err", {31'b0, bus.stk_err}, {31'b0, m_err});
    end
  end

  // Model state update at each active edge.
  always @(posedge clk) begin
    bit ei, es, eh;
    int ea;
    if (reset) begin
      m_mode = MR; stk.delete(); m_err = 1'b0; g1 = 1'b0; gs = 1'b0; pc = 0;
    end else begin
      model_eval(ei, ea, es, eh);
      pc = ei ? (pc + 1) % 64 : ea;
      if (m_mode == MR) begin
        case (bus.op)
          OP_CALL: if (stk.size() == DEPTH) m_err = 1'b1;
                   else stk.push_back((int'(bus.PCin) + 1) % 64);
          OP_RET:  if (stk.size() > 0) void'(stk.pop_back());
                   else m_err = 1'b1;
          OP_WAIT: if (int'(gs) != int'(bus.target) % 2) m_mode = MW;
          OP_HALT: m_mode = MH;
          default: ;
        endcase
      end else if (m_mode == MW) begin
        if (int'(gs) == int'(bus.target) % 2) m_mode = MR;
      end
      gs = g1;
      g1 = bus.go;
    end
  end

  task automatic drive(input int pcin, input op_t o, input int tgt, input bit z);
    bus.PCin   = 6'(pcin);
    bus.op     = o;
    bus.target = 6'(tgt);
    bus.zero   = z;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic op_t pick_op();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 30) return OP_ALU;
    if (r < 38) return OP_JMP;
    if (r < 50) return OP_BEQ;
    if (r < 62) return OP_BNE;
    if (r < 77) return OP_CALL;
    if (r < 92) return OP_RET;
    if (r < 98) return OP_WAIT;
    return OP_HALT;
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 64; i++) begin
      rom_op[i]  = pick_op();
      rom_tgt[i] = int'($urandom_range(0, 63));
    end
  endtask

  initial begin
    int halt_cnt;
    reset = 1'b1;
    bus.go = 1'b0;
    drive(0, OP_ALU, 0, 1'b0);
    step();
    chk_en = 1'b1;

    // 1: reset outputs, ALU increments, reset during HALT op
    at_neg();
    check("rst_PCincr", {31'b0, bus.PCincr}, 0);
    check("rst_Branchaddr", {26'b0, bus.Branchaddr}, 0);
    check("rst_stall", {31'b0, bus.stall}, 0);
    check("rst_halted", {31'b0, bus.halted}, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i, OP_ALU, 0, 1'b0);
      at_neg();
      check("alu_incr", {31'b0, bus.PCincr}, 1);
      step();
    end
    check("model_pc_after_alu", pc, 3);
    drive(3, OP_HALT, 0, 1'b0);
    reset = 1'b1;
    at_neg();
    check("rst_halt_halted", {31'b0, bus.halted}, 0);
    check("rst_halt_stall", {31'b0, bus.stall}, 0);
    step();
    reset = 1'b0;
    drive(3, OP_ALU, 0, 1'b0);
    at_neg();
    check("post_rst_run", {31'b0, bus.PCincr}, 1);
    step();

    // 2: relative branches with wrap
    drive(10, OP_BEQ, 'h3C, 1'b1); at_neg();
    check("beq_taken_incr", {31'b0, bus.PCincr}, 0);
    check("beq_taken_addr", {26'b0, bus.Branchaddr}, 6);
    step();
    drive(10, OP_BEQ, 'h3C, 1'b0); at_neg();
    check("beq_not_taken", {31'b0, bus.PCincr}, 1);
    step();
    drive(10, OP_BNE, 'h3C, 1'b0); at_neg();
    check("bne_taken_addr", {26'b0, bus.Branchaddr}, 6);
    step();
    drive(10, OP_BNE, 'h3C, 1'b1); at_neg();
    check("bne_not_taken", {31'b0, bus.PCincr}, 1);
    step();
    drive(62, OP_BEQ, 3, 1'b1); at_neg();
    check("beq_wrap_up", {26'b0, bus.Branchaddr}, 1);
    step();
    drive(0, OP_BNE, 'h3F, 1'b0); at_neg();
    check("bne_wrap_down", {26'b0, bus.Branchaddr}, 63);
    step();

    // 3: call/return, overflow, underflow
    drive(5, OP_CALL, 20, 1'b0); at_neg();
    check("call_addr", {26'b0, bus.Branchaddr}, 20);
    check("call_err0", {31'b0, bus.stk_err}, 0);
    step();
    drive(21, OP_RET, 0, 1'b0); at_neg();
    check("ret_addr", {26'b0, bus.Branchaddr}, 6);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(30 + k, OP_CALL, 40 + k, 1'b0); at_neg();
      check("nest_call_incr", {31'b0, bus.PCincr}, 0);
      check("nest_call_addr", {26'b0, bus.Branchaddr}, 40 + k);
      check("nest_err_before", {31'b0, bus.stk_err}, 0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      drive(50, OP_RET, 0, 1'b0); at_neg();
      check("overflow_err", {31'b0, bus.stk_err}, 1);
      check("nest_ret_addr", {26'b0, bus.Branchaddr}, 34 - k);
      step();
    end
    drive(50, OP_RET, 0, 1'b0); at_neg();
    check("underflow_incr", {31'b0, bus.PCincr}, 1);
    step();
    drive(51, OP_ALU, 0, 1'b0); at_neg();
    check("err_sticky", {31'b0, bus.stk_err}, 1);
    step();

    // 4: WAIT on go with 2-cycle synchroniser latency
    drive(15, OP_WAIT, 1, 1'b0); at_neg();
    check("wait_stall", {31'b0, bus.stall}, 1);
    check("wait_hold", {26'b0, bus.Branchaddr}, 15);
    step();
    at_neg();
    check("wait_state_stall", {31'b0, bus.stall}, 1);
    step();
    bus.go = 1'b1;
    at_neg(); check("go_lat0", {31'b0, bus.stall}, 1); step();
    at_neg(); check("go_lat1", {31'b0, bus.stall}, 1); step();
    at_neg();
    check("go_lat2_incr", {31'b0, bus.PCincr}, 1);
    check("go_lat2_stall", {31'b0, bus.stall}, 0);
    step();
    drive(16, OP_WAIT, 1, 1'b0); at_neg();
    check("wait_match_nostall", {31'b0, bus.stall}, 0);
    check("wait_match_incr", {31'b0, bus.PCincr}, 1);
    step();

    // 5: HALT holds until reset
    drive(9, OP_HALT, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      at_neg();
      check("halt_incr", {31'b0, bus.PCincr}, 0);
      check("halt_addr", {26'b0, bus.Branchaddr}, 9);
      check("halt_stall", {31'b0, bus.stall}, 1);
      if (c > 0) check("halt_halted", {31'b0, bus.halted}, 1);
      step();
    end
    reset = 1'b1; step(); reset = 1'b0;
    drive(9, OP_ALU, 0, 1'b0); at_neg();
    check("halt_exit_halted", {31'b0, bus.halted}, 0);
    check("halt_exit_err", {31'b0, bus.stk_err}, 0);
    step();

    // 6: reset during WAIT discards stack contents
    drive(1, OP_CALL, 10, 1'b0); step();
    drive(10, OP_CALL, 20, 1'b0); step();
    drive(20, OP_WAIT, 0, 1'b0); at_neg();
    check("wait6_stall", {31'b0, bus.stall}, 1);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    drive(20, OP_RET, 0, 1'b0); at_neg();
    check("ret_after_rst_incr", {31'b0, bus.PCincr}, 1);
    step();
    drive(21, OP_ALU, 0, 1'b0); at_neg();
    check("ret_after_rst_err", {31'b0, bus.stk_err}, 1);
    step();

    // Random program run
    reset = 1'b1; fill_rom(); drive(0, OP_ALU, 0, 1'b0); step();
    halt_cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      halt_cnt = (m_mode == MH) ? halt_cnt + 1 : 0;
      reset = (halt_cnt > 3) || ($urandom_range(0, 299) == 0);
      if (reset) fill_rom();
      if ($urandom_range(0, 7) == 0) bus.go = ~bus.go;
      drive(pc, rom_op[pc], rom_tgt[pc], 1'($urandom_range(0, 1)));
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
